// File: rtl/uart_receiver.sv
// uart_receiver: 8N2 UART deserialiser that assembles 48 received bytes into one
// 4x4 BTint matrix and presents it on packed buses with a valid/ready handshake.
module uart_receiver #(
    parameter int unsigned BIT_PERIOD = 10000000
) (
    input  logic           uart_receiver_clock,
    input  logic           uart_receiver_reset_active_low,
    input  logic           uart_receiver_input,
    output logic [127:0]   uart_receiver_output_btint_a,
    output logic [127:0]   uart_receiver_output_btint_b,
    output logic [31:0]    uart_receiver_output_overflow,
    output logic           uart_receiver_output_valid,
    input  logic           uart_receiver_output_ready,
    output logic           uart_receiver_frame_error,
    output logic           uart_receiver_overrun
);

    localparam logic [23:0] PERIOD      = 24'(BIT_PERIOD);
    localparam logic [23:0] HALF_PERIOD = 24'(BIT_PERIOD / 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic         rx_meta;
    logic         rx_s;

    state_t       state_q,   state_d;
    logic [23:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q,   shift_d;
    logic         byte_good;
    logic         byte_bad;

    // Byte position n is held as n = 3*elem + field.
    logic [3:0]   elem_q;
    logic [1:0]   field_q;
    logic         matrix_done;
    logic         load;

    logic [127:0] shadow_a;
    logic [127:0] shadow_b;
    logic [31:0]  shadow_ov;

    // NOTE: sequential blocks use non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
        if (!uart_receiver_reset_active_low) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_receiver_input;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
        if (!uart_receiver_reset_active_low) begin
            state_q   <= IDLE;
            bit_cnt_q <= 24'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    bit_cnt_d = HALF_PERIOD;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_cnt_q == 24'd1) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = PERIOD;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 24'd1;
                end
            end
            DATA: begin
                if (bit_cnt_q == 24'd1) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_cnt_d          = PERIOD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 24'd1;
                end
            end
            STOP: begin
                if (bit_cnt_q == 24'd1) begin
                    byte_good = rx_s;
                    byte_bad  = !rx_s;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign matrix_done = byte_good && (elem_q == 4'd15) && (field_q == 2'd2);
    assign load        = matrix_done && (!uart_receiver_output_valid || uart_receiver_output_ready);

    always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
        if (!uart_receiver_reset_active_low) begin
            elem_q  <= 4'd0;
            field_q <= 2'd0;
        end else if (byte_bad) begin
            elem_q  <= 4'd0;
            field_q <= 2'd0;
        end else if (byte_good) begin
            if (field_q == 2'd2) begin
                field_q <= 2'd0;
                elem_q  <= elem_q + 4'd1;
            end else begin
                field_q <= field_q + 2'd1;
            end
        end
    end

    // NOTE: the shadow matrix holds data only, so it is deliberately left without reset.
    always_ff @(posedge uart_receiver_clock) begin
        if (byte_good) begin
            case (field_q)
                2'd0:    shadow_a[{elem_q, 3'b000} +: 8] <= shift_q;
                2'd1:    shadow_b[{elem_q, 3'b000} +: 8] <= shift_q;
                2'd2:    shadow_ov[{elem_q, 1'b0} +: 2]  <= shift_q[1:0];
                default: ;
            endcase
        end
    end

    // The final byte is element 15's overflow byte, so it bypasses the shadow on a load.
    always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
        if (!uart_receiver_reset_active_low) begin
            uart_receiver_output_btint_a  <= 128'd0;
            uart_receiver_output_btint_b  <= 128'd0;
            uart_receiver_output_overflow <= 32'd0;
            uart_receiver_output_valid    <= 1'b0;
            uart_receiver_frame_error     <= 1'b0;
            uart_receiver_overrun         <= 1'b0;
        end else begin
            uart_receiver_frame_error <= byte_bad;
            if (load) begin
                uart_receiver_output_btint_a  <= shadow_a;
                uart_receiver_output_btint_b  <= shadow_b;
                uart_receiver_output_overflow <= {shift_q[1:0], shadow_ov[29:0]};
                uart_receiver_output_valid    <= 1'b1;
            end else if (uart_receiver_output_ready) begin
                uart_receiver_output_valid <= 1'b0;
            end
            if (matrix_done && !load) begin
                uart_receiver_overrun <= 1'b1;
            end
        end
    end

    logic unused_ov;
    assign unused_ov = ^shadow_ov[31:30];

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a driver serialises matrices, a monitor
// compares each presented matrix and each frame_error pulse against queued expectations.
module tb_uart_receiver;

    localparam int P = 16;
    localparam int unsigned STOP_LAT = 3 + P / 2 + 9 * P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         line = 1'b1;
    logic         ready = 1'b0;
    logic [127:0] out_a;
    logic [127:0] out_b;
    logic [31:0]  out_ov;
    logic         valid;
    logic         frame_error;
    logic         overrun;

    uart_receiver #(.BIT_PERIOD(P)) dut (
        .uart_receiver_clock           (clk),
        .uart_receiver_reset_active_low(rst_n),
        .uart_receiver_input           (line),
        .uart_receiver_output_btint_a  (out_a),
        .uart_receiver_output_btint_b  (out_b),
        .uart_receiver_output_overflow (out_ov),
        .uart_receiver_output_valid    (valid),
        .uart_receiver_output_ready    (ready),
        .uart_receiver_frame_error     (frame_error),
        .uart_receiver_overrun         (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [31:0]  ov;
        int unsigned  at;
    } exp_t;

    exp_t        sb[$];
    int unsigned fe_exp[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, out_a, 128'd0);
        check({tag, "_b"}, out_b, 128'd0);
        check({tag, "_ov"}, {96'd0, out_ov}, 128'd0);
        check({tag, "_valid"}, {127'd0, valid}, 128'd0);
        check({tag, "_ferr"}, {127'd0, frame_error}, 128'd0);
        check({tag, "_overrun"}, {127'd0, overrun}, 128'd0);
    endtask

    // Reference: byte 3e+f of the stream is field f of element e.
    function automatic exp_t model_of(input logic [7:0] m [48]);
        exp_t r;
        r.a  = '0;
        r.b  = '0;
        r.ov = '0;
        r.at = 0;
        for (int e = 0; e < 16; e++) begin
            r.a[e*8 +: 8]  = m[3*e];
            r.b[e*8 +: 8]  = m[3*e+1];
            r.ov[e*2 +: 2] = m[3*e+2][1:0];
        end
        return r;
    endfunction

    // Entered and left just after a falling clock edge.
    task automatic send_byte(input logic [7:0] d, input bit good_stop, input bit two_stop,
                             input bit pulse_ready);
        logic [10:0] frame;
        int unsigned sample_at;
        int          nbits;
        frame     = {1'b1, good_stop, d, 1'b0};
        nbits     = two_stop ? 11 : 10;
        sample_at = cyc + STOP_LAT;
        for (int k = 0; k < nbits * P; k++) begin
            line = frame[k/P];
            if (pulse_ready) ready = (cyc == sample_at - 1);
            @(negedge clk);
        end
    endtask

    task automatic send_matrix(input logic [7:0] m [48], input bit expect_load, input bit pulse_last);
        for (int i = 0; i < 48; i++) begin
            if (i == 47 && expect_load) begin
                exp_t e;
                e    = model_of(m);
                e.at = cyc + STOP_LAT;
                sb.push_back(e);
            end
            send_byte(m[i], 1'b1, 1'($urandom_range(0, 1)), pulse_last && (i == 47));
        end
    endtask

    task automatic random_matrix(output logic [7:0] m [48]);
        for (int i = 0; i < 48; i++) m[i] = 8'($urandom);
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_fall"}, {127'd0, valid}, 128'd0);
    endtask

    // Monitor: a matrix is presented when valid rises or stays high across an accepting edge.
    initial begin
        logic prev_valid;
        logic prev_fe;
        exp_t e;
        prev_valid = 1'b0;
        prev_fe    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_fe    = 1'b0;
            end else begin
                if (valid && (!prev_valid || ready)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_load actual=load_at_%0d required=no_load", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("load_cycle", 128'(cyc), 128'(e.at));
                        check("matrix_a", out_a, e.a);
                        check("matrix_b", out_b, e.b);
                        check("matrix_ov", {96'd0, out_ov}, {96'd0, e.ov});
                    end
                end
                if (frame_error) begin
                    if (prev_fe) begin
                        checks++;
                        failures++;
                        $display("FAIL ferr_width actual=2+cycles required=1");
                    end else if (fe_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ferr actual=pulse_at_%0d required=none", cyc);
                    end else begin
                        check("ferr_cycle", 128'(cyc), 128'(fe_exp.pop_front()));
                    end
                end
                prev_valid = valid;
                prev_fe    = frame_error;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m [48];
        exp_t       m4_exp;

        // Reset held with a toggling line.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            line = 1'($urandom);
            @(negedge clk);
        end
        check_zero("reset_hold");
        line  = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full matrix with the fixed pattern.
        for (int e = 0; e < 16; e++) begin
            m[3*e]   = 8'(e);
            m[3*e+1] = 8'(8'h80 | e);
            m[3*e+2] = 8'(8'hFC | (e & 3));
        end
        send_matrix(m, 1'b1, 1'b0);
        check("m1_valid", {127'd0, valid}, 128'd1);
        check("m1_a_lo", {120'd0, out_a[7:0]}, 128'h00);
        check("m1_a_hi", {120'd0, out_a[127:120]}, 128'h0F);
        check("m1_b_hi", {120'd0, out_b[127:120]}, 128'h8F);
        check("m1_ov_hi", {126'd0, out_ov[31:30]}, 128'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("m1_valid_hold", {127'd0, valid}, 128'd1);
        end
        accept("m1");

        // Framing error on byte 10, then a clean matrix with a glitch in the middle.
        random_matrix(m);
        for (int i = 0; i < 10; i++) send_byte(m[i], 1'b1, 1'b0, 1'b0);
        fe_exp.push_back(cyc + STOP_LAT);
        send_byte(m[10], 1'b0, 1'b1, 1'b0);
        repeat (P) @(negedge clk);
        random_matrix(m);
        for (int i = 0; i < 48; i++) begin
            if (i == 20) begin
                line = 1'b0;
                repeat (5) @(negedge clk);
                line = 1'b1;
                repeat (3 * P) @(negedge clk);
            end
            if (i == 47) begin
                exp_t e;
                e    = model_of(m);
                e.at = cyc + STOP_LAT;
                sb.push_back(e);
            end
            send_byte(m[i], 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("m3_valid", {127'd0, valid}, 128'd1);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        accept("m3");

        // Overrun: second matrix arrives while the first is still unaccepted.
        random_matrix(m);
        m4_exp = model_of(m);
        send_matrix(m, 1'b1, 1'b0);
        check("m4_overrun_clear", {127'd0, overrun}, 128'd0);
        random_matrix(m);
        send_matrix(m, 1'b0, 1'b0);
        check("m5_overrun_set", {127'd0, overrun}, 128'd1);
        check("m5_hold_a", out_a, m4_exp.a);
        check("m5_hold_b", out_b, m4_exp.b);
        check("m5_hold_ov", {96'd0, out_ov}, {96'd0, m4_exp.ov});
        repeat (4) @(negedge clk);
        accept("m4");
        check("overrun_sticky", {127'd0, overrun}, 128'd1);

        // Asynchronous reset in the middle of a byte.
        random_matrix(m);
        for (int i = 0; i < 3; i++) send_byte(m[i], 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            line = (k < P) ? 1'b0 : 1'($urandom);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            line = 1'($urandom);
        end
        check_zero("reset_toggle");
        @(negedge clk);
        line  = 1'b1;
        rst_n = 1'b1;
        repeat (3 * P) @(negedge clk);

        // Back-to-back: new matrix completes on the very edge the old one is accepted.
        random_matrix(m);
        send_matrix(m, 1'b1, 1'b0);
        check("m7_valid", {127'd0, valid}, 128'd1);
        random_matrix(m);
        send_matrix(m, 1'b1, 1'b1);
        check("m8_valid_kept", {127'd0, valid}, 128'd1);
        check("m8_no_overrun", {127'd0, overrun}, 128'd0);
        accept("m8");

        repeat (4) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);
        check("ferr_drained", 128'(fe_exp.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
